// File: rtl/sp_ram_block_reader_if.sv
// Bundle of the request, RAM-port and block-handshake signals of the
// read-side buffer controller. The master modport is the controller itself,
// the slave modport is its surroundings (requester, RAM and AES consumer).
//
// Handshake: a block transfers on every rising clk edge where
// blk_valid & blk_ready are both 1. While blk_valid is 1 and blk_ready is 0,
// blk_data stays unchanged. blk_valid never depends on blk_ready.
interface sp_ram_block_reader_if #(
   parameter int ADDR_W    = 14,
   parameter int BLK_BYTES = 16,
   parameter int NBLK_W    = 11
);
   // request side
   logic                     start;
   logic [ADDR_W-1:0]        base_addr;
   logic [NBLK_W-1:0]        num_blocks;
   logic                     busy;
   logic                     done;
   // RAM side
   logic                     ram_ce;
   logic                     ram_oce;
   logic                     ram_wre;
   logic                     ram_reset;
   logic [ADDR_W-1:0]        ram_ad;
   logic [7:0]               ram_dout;
   // block side
   logic [8*BLK_BYTES-1:0]   blk_data;
   logic                     blk_valid;
   logic                     blk_ready;

   modport master (
      input  start, base_addr, num_blocks, ram_dout, blk_ready,
      output busy, done, ram_ce, ram_oce, ram_wre, ram_reset, ram_ad,
             blk_data, blk_valid
   );

   modport slave (
      output start, base_addr, num_blocks, ram_dout, blk_ready,
      input  busy, done, ram_ce, ram_oce, ram_wre, ram_reset, ram_ad,
             blk_data, blk_valid
   );
endinterface

// File: rtl/sp_ram_block_reader.sv
// Read-side controller for the 8x16K single-port buffer RAM. Reads
// BLK_BYTES consecutive bytes per block, packs them big-endian (first byte
// in the MSBs) and offers each block over a valid/ready handshake.
// The RAM runs in bypass mode: data for the address sampled at edge N is
// on ram_dout during the cycle after edge N, so byte i is shifted in one
// cycle after its address cycle and the last byte is taken in DRAIN.
module sp_ram_block_reader #(
   parameter int ADDR_W    = 14,
   parameter int BLK_BYTES = 16,
   parameter int NBLK_W    = 11
) (
   input  logic                   clk,
   input  logic                   rst_n,
   sp_ram_block_reader_if.master  bus,
   output logic [2:0]             state_o
);

   localparam int CNT_W = (BLK_BYTES > 1) ? $clog2(BLK_BYTES) : 1;
   localparam int DW    = 8 * BLK_BYTES;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_READ    = 3'd1,
      S_DRAIN   = 3'd2,
      S_PRESENT = 3'd3,
      S_FIN     = 3'd4
   } state_t;

   state_t            state_q,   state_d;
   logic [ADDR_W-1:0] addr_q,    addr_d;
   logic [NBLK_W-1:0] num_q,     num_d;
   logic [NBLK_W-1:0] blk_cnt_q, blk_cnt_d;
   logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
   logic [DW-1:0]     data_q,    data_d;
   logic              valid_q,   valid_d;

   // State and datapath registers; reset clears everything, even mid-read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         num_q      <= '0;
         blk_cnt_q  <= '0;
         byte_cnt_q <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         num_q      <= num_d;
         blk_cnt_q  <= blk_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
      end
   end

   // Next-state logic: address stepping, byte packing and block handshake.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      num_d      = num_q;
      blk_cnt_d  = blk_cnt_q;
      byte_cnt_d = byte_cnt_q;
      data_d     = data_q;
      valid_d    = valid_q;
      unique case (state_q)
         S_IDLE: begin
            // start is only looked at here, so a start while busy is ignored
            if (bus.start) begin
               addr_d     = bus.base_addr;
               num_d      = bus.num_blocks;
               blk_cnt_d  = '0;
               byte_cnt_d = '0;
               state_d    = (bus.num_blocks == '0) ? S_FIN : S_READ;
            end
         end
         S_READ: begin
            // addr_q is on ram_ad this cycle; ram_dout holds the previous byte
            addr_d     = addr_q + ADDR_W'(1);
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
            if (byte_cnt_q != '0) begin
               data_d = {data_q[DW-9:0], bus.ram_dout};
            end
            if (byte_cnt_q == CNT_W'(BLK_BYTES - 1)) begin
               byte_cnt_d = '0;
               state_d    = S_DRAIN;
            end
         end
         S_DRAIN: begin
            data_d  = {data_q[DW-9:0], bus.ram_dout};
            valid_d = 1'b1;
            state_d = S_PRESENT;
         end
         S_PRESENT: begin
            if (bus.blk_ready) begin
               valid_d   = 1'b0;
               blk_cnt_d = blk_cnt_q + NBLK_W'(1);
               // addr_q already points at the first byte of the next block
               state_d   = (blk_cnt_q + NBLK_W'(1) == num_q) ? S_FIN : S_READ;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs decoded from state; the RAM is only clocked while issuing reads.
   always_comb begin
      bus.ram_ce    = (state_q == S_READ);
      bus.ram_oce   = 1'b1;
      bus.ram_wre   = 1'b0;
      bus.ram_reset = 1'b0;
      bus.ram_ad    = addr_q;
      bus.blk_data  = data_q;
      bus.blk_valid = valid_q;
      bus.busy      = (state_q == S_READ) || (state_q == S_DRAIN) ||
                      (state_q == S_PRESENT);
      bus.done      = (state_q == S_FIN);
      state_o       = state_q;
   end

endmodule

// File: tb/tb_sp_ram_block_reader.sv
// Directed and randomized bench for sp_ram_block_reader. A byte-array RAM
// model answers reads; expected blocks are computed directly from the
// array contents and the requested base address.
module tb_sp_ram_block_reader;

   localparam int ADDR_W    = 14;
   localparam int BLK_BYTES = 16;
   localparam int NBLK_W    = 11;
   localparam int DW        = 8 * BLK_BYTES;
   localparam int LAT       = BLK_BYTES + 1;

   logic clk;
   logic rst_n;
   logic [2:0] dbg_state;

   int checks = 0;
   int errors = 0;

   logic [7:0]        mem [0:(1<<ADDR_W)-1];
   logic [ADDR_W-1:0] addr_log[$];
   logic [DW-1:0]     exp_q[$];

   sp_ram_block_reader_if #(.ADDR_W(ADDR_W), .BLK_BYTES(BLK_BYTES), .NBLK_W(NBLK_W)) bus ();

   sp_ram_block_reader #(.ADDR_W(ADDR_W), .BLK_BYTES(BLK_BYTES), .NBLK_W(NBLK_W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .state_o (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model (bypass read) and address monitor
   initial bus.ram_dout = 8'h00;
   always @(posedge clk) begin
      if (bus.ram_ce) begin
         bus.ram_dout <= mem[bus.ram_ad];
         addr_log.push_back(bus.ram_ad);
      end
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference block: bytes base+16b .. base+16b+15, wrapping the address space.
   function automatic logic [DW-1:0] model_block(input logic [ADDR_W-1:0] base, input int b);
      logic [DW-1:0] blk;
      int a;
      blk = '0;
      for (int k = 0; k < BLK_BYTES; k++) begin
         a = (int'(base) + BLK_BYTES * b + k) % (1 << ADDR_W);
         blk[DW-1-8*k -: 8] = mem[a];
      end
      return blk;
   endfunction

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_ce"},    DW'(bus.ram_ce),    '0);
      chk({tag, "_ad"},    DW'(bus.ram_ad),    '0);
      chk({tag, "_data"},  bus.blk_data,       '0);
      chk({tag, "_valid"}, DW'(bus.blk_valid), '0);
      chk({tag, "_busy"},  DW'(bus.busy),      '0);
      chk({tag, "_done"},  DW'(bus.done),      '0);
   endtask

   // One full request: start pulse, every block accepted after `stall`
   // cycles of backpressure, optional stray start during the first read.
   task automatic run_req(input logic [ADDR_W-1:0] base, input int n, input int stall,
                          input bit poke, input string tag);
      int k;
      int bad;
      logic [DW-1:0] exp;
      addr_log.delete();
      exp_q.delete();
      for (int b = 0; b < n; b++) exp_q.push_back(model_block(base, b));

      @(negedge clk);
      bus.start      = 1'b1;
      bus.base_addr  = base;
      bus.num_blocks = NBLK_W'(n);
      @(negedge clk);
      bus.start      = 1'b0;
      bus.base_addr  = ADDR_W'($urandom);
      bus.num_blocks = NBLK_W'($urandom);

      if (n == 0) begin
         chk({tag, "_zero_done"}, DW'(bus.done), 1);
         chk({tag, "_zero_busy"}, DW'(bus.busy), 0);
         @(negedge clk);
         chk({tag, "_zero_done_end"}, DW'(bus.done), 0);
         chk({tag, "_zero_ce_cnt"}, DW'(addr_log.size()), 0);
         return;
      end
      chk({tag, "_busy_start"}, DW'(bus.busy), 1);

      for (int b = 0; b < n; b++) begin
         k = 0;
         while (!bus.blk_valid && k < 100) begin
            @(negedge clk);
            k++;
            if (poke && b == 0 && k == 5) begin
               bus.start      = 1'b1;
               bus.base_addr  = 14'h0100;
               bus.num_blocks = 11'd7;
            end else begin
               bus.start = 1'b0;
            end
         end
         bus.start = 1'b0;
         chk($sformatf("%s_lat_b%0d", tag, b), DW'(k), DW'(LAT));
         exp = exp_q.pop_front();
         chk($sformatf("%s_data_b%0d", tag, b), bus.blk_data, exp);
         for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk($sformatf("%s_hold_data_b%0d", tag, b), bus.blk_data, exp);
            chk($sformatf("%s_hold_valid_b%0d", tag, b), DW'(bus.blk_valid), 1);
         end
         bus.blk_ready = 1'b1;
         @(negedge clk);
         bus.blk_ready = 1'b0;
         chk($sformatf("%s_valid_drop_b%0d", tag, b), DW'(bus.blk_valid), 0);
         if (b == n - 1) begin
            chk({tag, "_done"}, DW'(bus.done), 1);
            chk({tag, "_busy_fin"}, DW'(bus.busy), 0);
         end else begin
            chk($sformatf("%s_busy_b%0d", tag, b), DW'(bus.busy), 1);
            chk($sformatf("%s_nodone_b%0d", tag, b), DW'(bus.done), 0);
         end
      end
      @(negedge clk);
      chk({tag, "_done_pulse_end"}, DW'(bus.done), 0);
      chk({tag, "_idle_busy"}, DW'(bus.busy), 0);

      chk({tag, "_addr_cnt"}, DW'(addr_log.size()), DW'(BLK_BYTES * n));
      bad = 0;
      for (int i = 0; i < addr_log.size(); i++) begin
         if (addr_log[i] !== ADDR_W'((int'(base) + i) % (1 << ADDR_W))) bad++;
      end
      chk({tag, "_addr_seq_bad"}, DW'(bad), 0);
   endtask

   initial begin
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'($urandom);
      for (int i = 0; i < 32; i++) mem[i] = 8'(i);

      bus.start      = 1'b0;
      bus.base_addr  = '0;
      bus.num_blocks = '0;
      bus.blk_ready  = 1'b0;
      rst_n          = 1'b0;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      chk("reset_wre",   DW'(bus.ram_wre),   0);
      chk("reset_rreset", DW'(bus.ram_reset), 0);
      chk("reset_oce",   DW'(bus.ram_oce),   1);
      rst_n = 1'b1;

      // single block 00..0F
      run_req(14'h0000, 1, 0, 1'b0, "single");
      chk("single_known_data", model_block(14'h0000, 0), 128'h000102030405060708090a0b0c0d0e0f);

      // backpressure, second block from 0x0010
      run_req(14'h0000, 2, 5, 1'b0, "bp");

      // address wrap
      run_req(14'h3FF8, 1, 0, 1'b0, "wrap");

      // zero blocks
      run_req(14'h0123, 0, 0, 1'b0, "zero");

      // start while busy is ignored
      run_req(14'h0040, 2, 1, 1'b1, "ign");

      // reset in the middle of a read
      @(negedge clk);
      bus.start      = 1'b1;
      bus.base_addr  = 14'h0200;
      bus.num_blocks = 11'd3;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (8) @(negedge clk);
      chk("midrst_ce_before", DW'(bus.ram_ce), 1);
      rst_n = 1'b0;
      #1;
      check_idle_outputs("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      run_req(14'h0200, 1, 0, 1'b0, "after_rst");

      // randomized requests
      for (int r = 0; r < 6; r++) begin
         run_req(ADDR_W'($urandom), $urandom_range(1, 3), $urandom_range(0, 4),
                 1'($urandom_range(0, 1)), $sformatf("rnd%0d", r));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
